serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 12 +
 rtl/half_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// Combinational half subtractor: diff = a - b, borrow when a=0 and b=1.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b;
    assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, behind a start/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             br_reg;
    logic             sa_reg;
    logic             sb_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             borrow_reg;
    logic             ovf_reg;

    // Full-subtractor cell: two half subtractors plus an OR for the borrow.
    logic             d0;
    logic             b0;
    logic             d_bit;
    logic             b1;
    logic             br_next;
    logic [WIDTH-1:0] work_next;

    half_subtractor u_hs0 (
        .a      (a_sh_reg[0]),
        .b      (b_sh_reg[0]),
        .diff   (d0),
        .borrow (b0)
    );

    half_subtractor u_hs1 (
        .a      (d0),
        .b      (br_reg),
        .diff   (d_bit),
        .borrow (b1)
    );

    assign br_next   = b0 | b1;
    assign work_next = {d_bit, work_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            work_reg   <= '0;
            diff_reg   <= '0;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            sa_reg     <= 1'b0;
            sb_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        sa_reg    <= a[WIDTH-1];
                        sb_reg    <= b[WIDTH-1];
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    br_reg   <= br_next;
                    work_reg <= work_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        // Result registers update only here, so RUN never exposes partial bits.
                        diff_reg   <= work_next;
                        borrow_reg <= br_next;
                        ovf_reg    <= (sa_reg != sb_reg) && (d_bit != sa_reg);
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and sequence bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    int vectors;
    int miscompares;
    int checks;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [7];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one operation from a negedge and wait for done; checks latency and busy shape.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string tag);
        int lat;
        lat = -1;
        start = 1'b1;
        a = op_a;
        b = op_b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 30; i++) begin
            if (busy && done) begin
                chk({tag, "_busy_and_done"}, 1, 0);
            end
            if (done) begin
                lat = i;
                break;
            end
            if (busy !== 1'b1) begin
                chk({tag, "_busy_during_run"}, {31'd0, busy}, 1);
            end
            @(negedge clk);
        end
        vectors++;
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        $display("op %s: 0x%02h - 0x%02h -> diff=0x%02h borrow=%0b ovf=%0b latency=%0d",
                 tag, op_a, op_b, diff, borrow_out, ovf, lat);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 0);
    endtask

    initial begin
        int n_done;
        int last_done;
        int sd;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rd;
        logic         ro;

        vectors     = 0;
        miscompares = 0;
        checks      = 0;

        vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
        vecs[6] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_diff", {24'd0, diff}, 0);
        chk("reset_borrow", {31'd0, borrow_out}, 0);
        chk("reset_ovf", {31'd0, ovf}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow,
                   vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // Second start while busy must be ignored.
        start = 1'b1;
        a = 8'h35;
        b = 8'h12;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i < 25; i++) begin
            if (i == 2) begin
                start = 1'b1;
                a = 8'h80;
                b = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (done) n_done++;
            if (busy && done) chk("ignore_busy_and_done", 1, 0);
            @(negedge clk);
        end
        vectors++;
        chk("ignore_done_count", n_done, 1);
        chk("ignore_diff", {24'd0, diff}, 32'h23);
        chk("ignore_borrow", {31'd0, borrow_out}, 0);
        chk("ignore_ovf", {31'd0, ovf}, 0);
        $display("op ignore_start: done pulses=%0d diff=0x%02h", n_done, diff);

        // Reset mid-operation aborts and clears the result registers.
        start = 1'b1;
        a = 8'h80;
        b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_diff", {24'd0, diff}, 0);
        chk("abort_borrow", {31'd0, borrow_out}, 0);
        chk("abort_ovf", {31'd0, ovf}, 0);
        $display("op abort: busy=%0b done=%0b diff=0x%02h", busy, done, diff);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) chk("abort_no_done", 1, 0);
            @(negedge clk);
        end
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "after_reset");

        // Held start: back-to-back operations every WIDTH+2 cycles.
        start = 1'b1;
        a = 8'h12;
        b = 8'h35;
        n_done = 0;
        last_done = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (last_done >= 0) chk("held_period", i - last_done, W + 2);
                chk("held_diff", {24'd0, diff}, 32'hDD);
                last_done = i;
            end
        end
        start = 1'b0;
        vectors++;
        chk("held_count", n_done, 4);
        $display("op held_start: done pulses=%0d", n_done);
        repeat (12) @(negedge clk);

        // Random sweep against a signed/unsigned reference.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rd = W'(int'(ra) - int'(rb));
            sd = int'($signed(ra)) - int'($signed(rb));
            ro = (sd > 127) || (sd < -128);
            run_op(ra, rb, rd, ra < rb, ro, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
